// File: rtl/clock_display_scan_pkg.sv
// Shared constants for the six-digit multiplexed seven-segment display driver.
package clock_disp_pkg;

  // {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG7_0    = 7'h3F;
  localparam logic [6:0] SEG7_1    = 7'h06;
  localparam logic [6:0] SEG7_2    = 7'h5B;
  localparam logic [6:0] SEG7_3    = 7'h4F;
  localparam logic [6:0] SEG7_4    = 7'h66;
  localparam logic [6:0] SEG7_5    = 7'h6D;
  localparam logic [6:0] SEG7_6    = 7'h7D;
  localparam logic [6:0] SEG7_7    = 7'h07;
  localparam logic [6:0] SEG7_8    = 7'h7F;
  localparam logic [6:0] SEG7_9    = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [2:0] DIG_SEC_U = 3'd0;
  localparam logic [2:0] DIG_SEC_T = 3'd1;
  localparam logic [2:0] DIG_MIN_U = 3'd2;
  localparam logic [2:0] DIG_MIN_T = 3'd3;
  localparam logic [2:0] DIG_HR_U  = 3'd4;
  localparam logic [2:0] DIG_HR_T  = 3'd5;

  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
    logic       sec_en;
    logic       blink_hour;
    logic       blink_min;
    logic       alarm_on;
  } time_snap_t;

endpackage

// File: rtl/clock_display_scan_if.sv
// Time bus from the clock core into the display driver.
interface clock_display_scan_if;
  logic [7:0] hour;
  logic [7:0] min;
  logic [7:0] sec;
  logic       sec_en;
  logic       blink_hour;
  logic       blink_min;
  logic       alarm_on;

  modport master (output hour, min, sec, sec_en, blink_hour, blink_min, alarm_on);
  modport slave  (input  hour, min, sec, sec_en, blink_hour, blink_min, alarm_on);
endinterface

// File: rtl/bcd_to_seg7.sv
// BCD nibble to seven-segment pattern; non-decimal nibbles and blank give all-off.
module bcd_to_seg7
  import clock_disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (nibble)
        4'd0:    seg = SEG7_0;
        4'd1:    seg = SEG7_1;
        4'd2:    seg = SEG7_2;
        4'd3:    seg = SEG7_3;
        4'd4:    seg = SEG7_4;
        4'd5:    seg = SEG7_5;
        4'd6:    seg = SEG7_6;
        4'd7:    seg = SEG7_7;
        4'd8:    seg = SEG7_8;
        4'd9:    seg = SEG7_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit scanned display driver: guard-interval scanning, per-frame snapshot,
// edit-field blinking, 1 Hz colon and alarm dot. All outputs registered.
module clock_display_scan
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int GUARD        = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  clock_display_scan_if.slave  tbus,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic [5:0]           dig_sel
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  time_snap_t       snap_q, snap_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [5:0]       dig_sel_q, dig_sel_d;

  logic       slot_wrap, frame_end, slot_on;
  logic [3:0] nib;
  logic       blink_blank, dig_blank, colon, dp_on;
  logic [6:0] seg_dec;

  bcd_to_seg7 u_dec (
    .nibble (nib),
    .blank  (dig_blank),
    .seg    (seg_dec)
  );

  always_comb begin
    slot_wrap = (cnt_q == CNT_W'(SCAN_DIV - 1));
    frame_end = slot_wrap && (idx_q == DIG_HR_T);
    slot_on   = (cnt_q >= CNT_W'(GUARD));

    cnt_d = slot_wrap ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_wrap) idx_d = (idx_q == DIG_HR_T) ? DIG_SEC_U : idx_q + 3'd1;

    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_end) begin
      if (frame_cnt_q == FRM_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    // Frame-start snapshot keeps all six digits of one frame coherent.
    snap_d = snap_q;
    if (cnt_q == '0 && idx_q == DIG_SEC_U)
      snap_d = '{hour: tbus.hour, min: tbus.min, sec: tbus.sec, sec_en: tbus.sec_en,
                 blink_hour: tbus.blink_hour, blink_min: tbus.blink_min,
                 alarm_on: tbus.alarm_on};

    nib         = 4'hF;
    blink_blank = 1'b0;
    case (idx_q)
      DIG_SEC_U: nib = snap_q.sec[3:0];
      DIG_SEC_T: nib = snap_q.sec[7:4];
      DIG_MIN_U: begin nib = snap_q.min[3:0];  blink_blank = snap_q.blink_min  & blink_phase_q; end
      DIG_MIN_T: begin nib = snap_q.min[7:4];  blink_blank = snap_q.blink_min  & blink_phase_q; end
      DIG_HR_U:  begin nib = snap_q.hour[3:0]; blink_blank = snap_q.blink_hour & blink_phase_q; end
      DIG_HR_T:  begin nib = snap_q.hour[7:4]; blink_blank = snap_q.blink_hour & blink_phase_q; end
      default:   nib = 4'hF;
    endcase

    dig_blank = blink_blank
              | (!snap_q.sec_en && (idx_q == DIG_SEC_U || idx_q == DIG_SEC_T))
              | (idx_q == DIG_HR_T && nib == 4'd0);

    // Colon is steady outside time mode, otherwise toggles with the seconds LSB.
    colon = !snap_q.sec_en || !snap_q.sec[0];
    dp_on = 1'b0;
    case (idx_q)
      DIG_SEC_U: dp_on = snap_q.alarm_on;
      DIG_MIN_U,
      DIG_HR_U:  dp_on = colon && !blink_blank;
      default:   dp_on = 1'b0;
    endcase

    seg_d     = slot_on ? seg_dec : SEG_BLANK;
    dp_d      = slot_on && dp_on;
    dig_sel_d = slot_on ? ~(6'b000001 << idx_q) : 6'b111111;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= DIG_SEC_U;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      snap_q        <= '0;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b0;
      dig_sel_q     <= 6'b111111;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      snap_q        <= snap_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      dig_sel_q     <= dig_sel_d;
    end
  end

  assign seg     = seg_q;
  assign dp      = dp_q;
  assign dig_sel = dig_sel_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Bench for clock_display_scan at SCAN_DIV=8, GUARD=2, BLINK_FRAMES=4.
module tb_clock_display_scan;
  localparam int SD = 8;
  localparam int GD = 2;
  localparam int BF = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] dig_sel;

  always #5 clk = ~clk;

  clock_display_scan_if tb_if();

  clock_display_scan #(.SCAN_DIV(SD), .GUARD(GD), .BLINK_FRAMES(BF)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tbus    (tb_if.slave),
    .seg     (seg),
    .dp      (dp),
    .dig_sel (dig_sel)
  );

  typedef struct {
    int          edge_n;
    string       nm;
    logic [13:0] exp;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [7:0]      hour;
    logic [7:0]      min;
    logic [7:0]      sec;
    logic            sec_en;
    logic            alarm_on;
    logic [5:0][6:0] segs;
    logic [5:0]      dps;
  } vec_t;
  vec_t vt[5];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [13:0] act, input logic [13:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got dig_sel=%b dp=%b seg=%h, want dig_sel=%b dp=%b seg=%h",
               nm, act[13:8], act[7], act[6:0], exp[13:8], exp[7], exp[6:0]);
    end
  endtask

  task automatic push(input int e, input string nm, input logic [5:0] ds,
                      input logic [6:0] sg, input logic d);
    sb_t s;
    s.edge_n = e; s.nm = nm; s.exp = {ds, d, sg};
    sbq.push_back(s);
  endtask

  // Edge number (counted from reset release) sampled mid-ON for digit d of frame f.
  function automatic int ed(input int f, input int d);
    return f * 6 * SD + d * SD + 5;
  endfunction

  function automatic logic [5:0] sel(input int d);
    logic [5:0] one;
    one = 6'b000001;
    return ~(one << d);
  endfunction

  task automatic set_in(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                        input logic se, input logic bh, input logic bm, input logic al);
    tb_if.hour = h; tb_if.min = m; tb_if.sec = s; tb_if.sec_en = se;
    tb_if.blink_hour = bh; tb_if.blink_min = bm; tb_if.alarm_on = al;
  endtask

  // Leaves rst_n released on a falling edge, so the next rising edge is edge 1.
  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(nm, {dig_sel, dp, seg}, {6'b111111, 1'b0, 7'h00});
    rst_n = 1'b1;
  endtask

  task automatic run_checks(input int last);
    sb_t s;
    for (int e = 1; e <= last; e++) begin
      @(posedge clk);
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].edge_n == e) begin
        s = sbq.pop_front();
        check(s.nm, {dig_sel, dp, seg}, s.exp);
      end
    end
    if (sbq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL sb_drain: %0d entries left, want 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{8'h09, 8'h45, 8'h37, 1'b1, 1'b0,
              {7'h00, 7'h6F, 7'h66, 7'h6D, 7'h4F, 7'h07}, 6'b000000};
    vt[1] = '{8'h12, 8'hA5, 8'h37, 1'b0, 1'b1,
              {7'h06, 7'h5B, 7'h00, 7'h6D, 7'h00, 7'h00}, 6'b010101};
    vt[2] = '{8'h23, 8'h59, 8'h08, 1'b1, 1'b0,
              {7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h3F, 7'h7F}, 6'b010100};
    vt[3] = '{8'h10, 8'h26, 8'h14, 1'b1, 1'b1,
              {7'h06, 7'h3F, 7'h5B, 7'h7D, 7'h06, 7'h66}, 6'b010101};
    vt[4] = '{8'h0B, 8'h00, 8'h00, 1'b1, 1'b0,
              {7'h00, 7'h00, 7'h3F, 7'h3F, 7'h3F, 7'h3F}, 6'b010100};

    set_in(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Table vectors: one full frame after a fresh reset.
    for (int i = 0; i < 5; i++) begin
      set_in(vt[i].hour, vt[i].min, vt[i].sec, vt[i].sec_en, 1'b0, 1'b0, vt[i].alarm_on);
      do_reset($sformatf("vec%0d_reset", i));
      for (int d = 0; d < 6; d++)
        push(ed(0, d), $sformatf("vec%0d_dig%0d", i, d), sel(d), vt[i].segs[d], vt[i].dps[d]);
      run_checks(ed(0, 5));
    end

    // Release timing: guard then idx0, guard then idx1.
    set_in(8'h09, 8'h45, 8'h37, 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset("rel_reset");
    push(1,  "rel_e1",  6'b111111, 7'h00, 1'b0);
    push(2,  "rel_e2",  6'b111111, 7'h00, 1'b0);
    push(3,  "rel_e3",  6'b111110, 7'h07, 1'b0);
    push(8,  "rel_e8",  6'b111110, 7'h07, 1'b0);
    push(10, "rel_e10", 6'b111111, 7'h00, 1'b0);
    push(11, "rel_e11", 6'b111101, 7'h4F, 1'b0);
    run_checks(11);

    // Mid-frame hour change must wait for the next snapshot.
    set_in(8'h09, 8'h45, 8'h37, 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset("tear_reset");
    push(ed(0, 4), "tear_f0_hu", sel(4), 7'h6F, 1'b0);
    push(ed(0, 5), "tear_f0_ht", sel(5), 7'h00, 1'b0);
    push(ed(1, 4), "tear_f1_hu", sel(4), 7'h5B, 1'b0);
    push(ed(1, 5), "tear_f1_ht", sel(5), 7'h06, 1'b0);
    fork
      begin repeat (20) @(posedge clk); #1 tb_if.hour = 8'h12; end
      run_checks(ed(1, 5));
    join

    // Blink: m=0 edits minutes, m=1 edits hours; frames 4-7 blanked.
    for (int m = 0; m < 2; m++) begin
      set_in(8'h09, 8'h45, 8'h36, 1'b1, m == 1, m == 0, 1'b0);
      do_reset($sformatf("blink%0d_reset", m));
      for (int f = 0; f < 9; f++) begin
        automatic logic vis = (f < 4) || (f >= 8);
        automatic logic mv  = (m == 1) || vis;
        automatic logic hv  = (m == 0) || vis;
        push(ed(f, 2), $sformatf("blink%0d_f%0d_mu", m, f), sel(2), mv ? 7'h6D : 7'h00, mv);
        push(ed(f, 3), $sformatf("blink%0d_f%0d_mt", m, f), sel(3), mv ? 7'h66 : 7'h00, 1'b0);
        push(ed(f, 4), $sformatf("blink%0d_f%0d_hu", m, f), sel(4), hv ? 7'h6F : 7'h00, hv);
      end
      run_checks(ed(8, 4));
    end

    // Asynchronous reset during an ON slot, then restart from idx0.
    set_in(8'h09, 8'h45, 8'h37, 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset("arst_reset");
    repeat (30) @(posedge clk);
    #1 check("arst_pre", {dig_sel, dp, seg}, {6'b110111, 1'b0, 7'h66});
    #1 rst_n = 1'b0;
    #1 check("arst_now", {dig_sel, dp, seg}, {6'b111111, 1'b0, 7'h00});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push(2, "arst_e2", 6'b111111, 7'h00, 1'b0);
    push(3, "arst_e3", 6'b111110, 7'h07, 1'b0);
    run_checks(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_display_scan.md
# clock_display_scan

Multiplexed six-digit seven-segment display driver that consumes the timekeeper's BCD `hour`/`min`/`sec` bus and edit indicators and drives a common-anode LED panel. It scans one digit at a time with an anti-ghosting guard interval, snapshots the time bus once per frame to prevent tearing, blinks the field being edited, blanks invalid or disabled digits, and drives a 1 Hz colon and an alarm dot. It sits between the clock core and the board pins.

## Interface
- `SCAN_DIV`, 1000: clock cycles per digit slot; legal range is GUARD+1 and above.
- `GUARD`, 16: cycles at the start of each slot with all digits off; legal range is 1 and above.
- `BLINK_FRAMES`, 64: frames per blink half-period; legal range is 1 and above.
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `hour`  in  8  BCD hours, {tens, units}.
- `min`  in  8  BCD minutes.
- `sec`  in  8  BCD seconds.
- `sec_en`  in  1  1 shows the seconds digits; 0 blanks them (alarm and set modes).
- `blink_hour`  in  1  the hour field is being edited; blink its digits.
- `blink_min`  in  1  the minute field is being edited; blink its digits.
- `alarm_on`  in  1  an alarm is armed; lights the dot on digit 0.
- `seg`  out  7  {g,f,e,d,c,b,a}, active-high.
- `dp`  out  1  decimal point, active-high.
- `dig_sel`  out  6  one-hot, active-low digit enable. Bit 0 is seconds units; bit 5 is hour tens.

## Operation
- Counters:
  - `cnt` runs 0..SCAN_DIV-1 and wraps.
  - `idx` runs 0..5 and increments when `cnt` wraps; 5 wraps to 0.
  - A frame is 6×SCAN_DIV cycles.
- Slot states:
  - OFF while `cnt` < GUARD: `dig_sel`=6'b111111, `seg`=0, `dp`=0.
  - ON while `cnt` ≥ GUARD: `dig_sel[idx]`=0 and all other bits 1; `seg`/`dp` decoded for `idx`.
- Snapshot:
  - Taken on the edge where `cnt`==0 and `idx`==0.
  - Registers `hour`, `min`, `sec`, `sec_en`, `blink_hour`, `blink_min`, `alarm_on`.
  - All display decoding uses only snapshot values.
- Digit map:
  - idx0 = sec[3:0], idx1 = sec[7:4].
  - idx2 = min[3:0], idx3 = min[7:4].
  - idx4 = hour[3:0], idx5 = hour[7:4].
- Blanking (`seg`=0, with the digit still enabled), any one of:
  - The nibble is greater than 9.
  - idx0/1 while `sec_en`=0.
  - idx5 with nibble 0 (leading zero).
  - idx2/3 while `blink_min` and `blink_phase`=1.
  - idx4/5 while `blink_hour` and `blink_phase`=1.
- Blink:
  - `frame_cnt` increments at the last cycle of a frame (`cnt`=SCAN_DIV-1, `idx`=5).
  - At BLINK_FRAMES-1 it wraps to 0 and toggles `blink_phase`. `blink_phase` resets to 0 (visible).
- `dp`:
  - Colon on idx2 and idx4: lit when `sec_en`=0; when `sec_en`=1, lit when snapshot sec[0]=0.
  - Dot on idx0: lit when `alarm_on`. When idx0 is blanked, `dp` still follows `alarm_on`.
  - Blink blanking also clears the colon on idx4/idx2 when that digit is blanked.
- Decode patterns:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66
  - 5=6D, 6=7D, 7=07, 8=7F, 9=6F

## Timing
- Reset values: `seg`=0, `dp`=0, `dig_sel`=6'b111111; `cnt`=`idx`=`frame_cnt`=0; `blink_phase`=0; snapshot=0.
- All outputs are registered. Each output reflects the counter state before the edge (1-cycle latency).
- After `rst_n` deasserts:
  - Edge 1 takes the snapshot.
  - Edge GUARD+1 first drives `dig_sel`=6'b111110.
- Digit ON time is SCAN_DIV−GUARD cycles. Two digits are never enabled in the same cycle; every change between digits passes through at least GUARD cycles of all-off.
- Input changes mid-frame are not shown until the next frame snapshot. Worst-case display latency is 6×SCAN_DIV+GUARD+1 cycles.
- Reset asserted mid-slot forces the reset values immediately (asynchronously). Scanning restarts at idx0.

## Structure
- Package `clock_disp_pkg` holds:
  - The seven-segment pattern constants.
  - Digit index constants (`DIG_SEC_U` … `DIG_HR_T`).
  - The blank pattern.
- Sub-module `bcd_to_seg7` is combinational: 4-bit nibble plus `blank` in, 7-bit `seg` out. Values above 9 produce all-zero.

## Test plan
All scenarios use SCAN_DIV=8, GUARD=2, BLINK_FRAMES=4.

- Reset, then release: outputs hold at reset values through edge 2. At edge 3, `dig_sel`=111110. At edge 11, `dig_sel`=111101.
- hour=09, min=45, sec=37, sec_en=1:
  - idx0 `seg`=07 (dp=0), idx1=4F, idx2=6D with dp=0 (sec odd), idx3=66, idx4=6F, idx5=00 (leading zero blanked).
- Change hour to 12 at cycle 20 (mid-frame): idx4/5 still show 9/blank in that frame. The next frame shows 2/1 (5B/06).
- blink_min=1:
  - idx2/3 visible for frames 0–3.
  - idx2/3 show `seg`=0 for frames 4–7 while their `dig_sel` bit still pulses low.
  - Hour digits are unaffected.
- sec_en=0, min=A5, alarm_on=1:
  - idx0/1 `seg`=0, with dp=1 on idx0.
  - idx3 `seg`=0 (invalid nibble).
  - Colon dp=1 steady on idx2 and idx4.
- Assert rst_n low at cycle 30 (mid-ON): `dig_sel`=111111 within the same cycle. After release, the first digit enabled is idx0, at edge 3.
